demux_1to8_buf: RTL

- 1-to-8 demultiplexer with per-channel output buffering.
- Takes one 8-bit input stream and steers each accepted beat to one of eight output channels.
- Channel is chosen by an explicit select or by an internal round-robin pointer.
- Sits on the distribution side of an 8-channel data path, feeding eight independent consumers, each with valid/ready backpressure.

---
 rtl/demux_1to8_buf.sv | 101 ++++++++++
 1 files changed

// File: rtl/demux_1to8_buf.sv
// demux_1to8_buf: 1-to-8 demultiplexer with one holding register per channel.
// Each accepted input beat is steered to the channel picked by in_sel, or by an
// internal round-robin pointer when rr_mode=1. Every channel has a one-deep
// buffer with valid/ready backpressure, so it can take a beat every cycle.
// Optional feature: define DEMUX_STAT_EN to add a saturating accepted-beat
// counter (beat_cnt) with a synchronous clear input (stat_clr).
module demux_1to8_buf #(
    parameter int DATA_W = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic [2:0]          in_sel,
    input  logic                rr_mode,
    output logic                in_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic [7:0]          out_valid,
    input  logic [7:0]          out_ready,
`ifdef DEMUX_STAT_EN
    input  logic                stat_clr,
    output logic [15:0]         beat_cnt,
`endif
    output logic [2:0]          cur_ch
);

    // Per-channel holding registers; element k maps onto out_data slice k.
    logic [7:0][DATA_W-1:0] data_q, data_d;
    logic [7:0]             valid_q, valid_d;
    logic [2:0]             rr_ptr_q, rr_ptr_d;
    logic                   accept;

    // Destination select, input-side ready and the accept handshake.
    always_comb begin
        cur_ch   = rr_mode ? rr_ptr_q : in_sel;
        in_ready = !valid_q[cur_ch] || out_ready[cur_ch];
        accept   = in_valid && in_ready;
    end

    // Next state: every channel drains on its own ready, then the addressed
    // channel is loaded, so a load on the same edge as a drain keeps valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        if (accept) begin
            data_d[cur_ch]  = in_data;
            valid_d[cur_ch] = 1'b1;
        end
    end

    // Round-robin pointer only moves on an accept in round-robin mode, so a
    // full channel stalls the rotation instead of being skipped.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && rr_mode) begin
            rr_ptr_d = rr_ptr_q + 3'd1;
        end
    end

    // Channel buffers and pointer; reset discards anything buffered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q   <= '0;
            valid_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

`ifdef DEMUX_STAT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    // Saturating count of accepted beats; a clear beats a simultaneous accept.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (stat_clr) begin
            beat_cnt_d = '0;
        end else if (accept && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
